// File: rtl/readout_sequencer.sv
// readout_sequencer: output stage of the processor. A rising edge on readout_req
// freezes the core and streams a framed register dump (header, NREGS bytes, XOR
// checksum). A rising edge on sayhi_req streams "HI\n". Bytes leave over a
// valid/ready port; requests arriving while busy are dropped, not queued.
module readout_sequencer #(
  parameter int          NREGS = 8,
  parameter logic [7:0]  HDR   = 8'hA5,
  localparam int         AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          readout_req,
  input  logic          sayhi_req,
  output logic          halt,
  output logic [AW-1:0] reg_addr,
  input  logic [7:0]    reg_data,
  output logic [7:0]    out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_QUIESCE = 3'd1;
  localparam logic [2:0] S_HDR     = 3'd2;
  localparam logic [2:0] S_REG     = 3'd3;
  localparam logic [2:0] S_CSUM    = 3'd4;
  localparam logic [2:0] S_MSG     = 3'd5;

  localparam logic [AW-1:0] LAST_ADDR = AW'(NREGS - 1);

  logic [2:0]    state_q,     state_d;
  logic          halt_q,      halt_d;
  logic [AW-1:0] reg_addr_q,  reg_addr_d;
  logic [7:0]    out_data_q,  out_data_d;
  logic          out_valid_q, out_valid_d;
  logic [7:0]    csum_q,      csum_d;
  logic [1:0]    msg_idx_q,   msg_idx_d;
  logic          readout_q;
  logic          sayhi_q;

  logic readout_edge;
  logic sayhi_edge;
  logic accept;

  assign readout_edge = readout_req & ~readout_q;
  assign sayhi_edge   = sayhi_req & ~sayhi_q;
  assign accept       = out_valid_q & out_ready;

  // Next-state logic: one byte per accept, everything held while stalled.
  always_comb begin
    state_d     = state_q;
    halt_d      = halt_q;
    reg_addr_d  = reg_addr_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    csum_d      = csum_q;
    msg_idx_d   = msg_idx_q;
    case (state_q)
      S_IDLE: begin
        // Readout takes priority when both edges land in the same cycle.
        if (readout_edge) begin
          state_d    = S_QUIESCE;
          halt_d     = 1'b1;
          reg_addr_d = '0;
          csum_d     = '0;
        end else if (sayhi_edge) begin
          state_d     = S_MSG;
          msg_idx_d   = 2'd0;
          out_data_d  = 8'h48;
          out_valid_d = 1'b1;
        end
      end
      S_QUIESCE: begin
        // One settle cycle so the core is frozen before the first register read.
        state_d     = S_HDR;
        out_data_d  = HDR;
        out_valid_d = 1'b1;
      end
      S_HDR: begin
        if (accept) state_d = S_REG;
      end
      S_REG: begin
        // The offered byte is reg_data at reg_addr_q, so bumping the address
        // on accept presents the next register in the following cycle.
        if (accept) begin
          csum_d = csum_q ^ reg_data;
          if (reg_addr_q == LAST_ADDR) begin
            state_d    = S_CSUM;
            out_data_d = csum_q ^ reg_data;
          end else begin
            reg_addr_d = reg_addr_q + AW'(1);
          end
        end
      end
      S_CSUM: begin
        if (accept) begin
          state_d     = S_IDLE;
          halt_d      = 1'b0;
          out_valid_d = 1'b0;
          reg_addr_d  = '0;
        end
      end
      S_MSG: begin
        if (accept) begin
          case (msg_idx_q)
            2'd0: begin
              out_data_d = 8'h49;
              msg_idx_d  = 2'd1;
            end
            2'd1: begin
              out_data_d = 8'h0A;
              msg_idx_d  = 2'd2;
            end
            default: begin
              state_d     = S_IDLE;
              out_valid_d = 1'b0;
              msg_idx_d   = 2'd0;
            end
          endcase
        end
      end
      default: begin
        state_d     = S_IDLE;
        halt_d      = 1'b0;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State registers with asynchronous reset; request levels sampled every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      halt_q      <= 1'b0;
      reg_addr_q  <= '0;
      out_data_q  <= 8'h00;
      out_valid_q <= 1'b0;
      csum_q      <= 8'h00;
      msg_idx_q   <= 2'd0;
      readout_q   <= 1'b0;
      sayhi_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      halt_q      <= halt_d;
      reg_addr_q  <= reg_addr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      csum_q      <= csum_d;
      msg_idx_q   <= msg_idx_d;
      readout_q   <= readout_req;
      sayhi_q     <= sayhi_req;
    end
  end

  assign halt      = halt_q;
  assign reg_addr  = reg_addr_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q != S_IDLE);
  // Register bytes pass straight through so back-to-back accepts need no bubble.
  assign out_data  = (state_q == S_REG) ? reg_data : out_data_q;

endmodule
